// File: rtl/bus_slave.sv
// bus_slave: serial-bus slave endpoint with a local byte memory.
// Deserialises a 14-bit address (LSB first), a 3-bit burst code and write
// data, stores bursts of 1..8 bytes, and serialises read bursts back to
// the master. The SLAVE_WRITE_ACK_EN macro, when defined, adds a one-cycle
// slave_valid pulse after the last byte of a matched write frame.
module bus_slave #(
    parameter logic [1:0] SLAVE_ID = 2'b10,
    parameter int         MEM_AW   = 12
) (
    input  logic clock,
    input  logic reset,
    input  logic valid,
    input  logic addr_tx,
    input  logic burst_mode,
    input  logic data_tx,
    input  logic read_en,
    output logic slave_ready,
    output logic slave_valid,
    output logic data_rx
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        RLOAD,
        RDATA,
        IGNORE,
        DONE
    } state_t;

    state_t state, state_n;

    // Control: frame counters and the latched direction
    logic [3:0] addr_cnt;
    logic [2:0] bit_cnt;
    logic [2:0] byte_cnt;
    logic       rd_q;

    // Data: shift registers, burst pointer and the byte array
    logic [12:0]       addr_sh;
    logic [2:0]        burst_sh;
    logic [6:0]        wsh;
    logic [7:0]        rsh;
    logic [MEM_AW-1:0] ptr;
    logic [7:0]        mem [2**MEM_AW];

    logic [13:0] addr_full;
    logic        addr_done;
    logic        byte_end;
    logic        last_byte;
    logic [7:0]  wbyte;
    logic        rd_active;
    logic        wr_ack;

    // Bit 13 is still on the wire during the last address cycle, so the
    // decode combines it with the 13 bits already shifted in.
    assign addr_full = {addr_tx, addr_sh};
    assign addr_done = (state == ADDR) && (addr_cnt == 4'd13);
    assign byte_end  = (bit_cnt == 3'd7);
    assign last_byte = (byte_cnt == burst_sh);
    assign wbyte     = {data_tx, wsh};
    assign rd_active = (state == RDATA) && valid;

`ifdef SLAVE_WRITE_ACK_EN
    logic ack_q;

    // Write acknowledge: registered so it lands on the first DONE cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= (state == WDATA) && valid && byte_end && last_byte;
        end
    end

    assign wr_ack = ack_q;
`else
    assign wr_ack = 1'b0;
`endif

    assign slave_ready = (state == IDLE);
    assign slave_valid = rd_active || wr_ack;
    assign data_rx     = rd_active ? rsh[0] : 1'b0;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic; a dropped valid aborts any active frame
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (valid) state_n = ADDR;
            end
            ADDR: begin
                if (!valid) begin
                    state_n = IDLE;
                end else if (addr_cnt == 4'd13) begin
                    if (addr_full[13:12] != SLAVE_ID) state_n = IGNORE;
                    else if (rd_q)                    state_n = RLOAD;
                    else                              state_n = WDATA;
                end
            end
            WDATA, RDATA: begin
                if (!valid)                     state_n = IDLE;
                else if (byte_end && last_byte) state_n = DONE;
            end
            RLOAD: begin
                state_n = valid ? RDATA : IDLE;
            end
            IGNORE, DONE: begin
                if (!valid) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Frame counters and direction latch
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_cnt <= 4'd0;
            bit_cnt  <= 3'd0;
            byte_cnt <= 3'd0;
            rd_q     <= 1'b0;
        end else begin
            if (state == IDLE && valid) begin
                addr_cnt <= 4'd1;
                bit_cnt  <= 3'd0;
                byte_cnt <= 3'd0;
                rd_q     <= read_en;
            end else if (state == ADDR) begin
                addr_cnt <= addr_cnt + 4'd1;
            end else if ((state == WDATA || state == RDATA) && valid) begin
                bit_cnt <= bit_cnt + 3'd1;
                if (byte_end) byte_cnt <= byte_cnt + 3'd1;
            end
        end
    end

    // Address/burst deserialisers, write shifter, read shifter and pointer
    always_ff @(posedge clock) begin
        if ((state == IDLE && valid) || state == ADDR) begin
            addr_sh <= {addr_tx, addr_sh[12:1]};
        end
        if ((state == IDLE && valid) || (state == ADDR && addr_cnt < 4'd3)) begin
            burst_sh <= {burst_mode, burst_sh[2:1]};
        end
        if (addr_done) begin
            ptr <= addr_full[MEM_AW-1:0];
        end
        if (state == WDATA && valid) begin
            wsh <= {data_tx, wsh[6:1]};
            if (byte_end) ptr <= ptr + 1'b1;
        end
        if (state == RLOAD && valid) begin
            rsh <= mem[ptr];
            ptr <= ptr + 1'b1;
        end
        if (rd_active) begin
            if (byte_end) begin
                rsh <= mem[ptr];
                ptr <= ptr + 1'b1;
            end else begin
                rsh <= {1'b0, rsh[7:1]};
            end
        end
    end

    // Byte write on the eighth bit; a partial byte never reaches memory
    always_ff @(posedge clock) begin
        if (state == WDATA && valid && byte_end) begin
            mem[ptr] <= wbyte;
        end
    end

endmodule

// File: tb/tb_bus_slave.sv
// Bench for bus_slave: frames are driven bit-serially, a byte-array model
// predicts every slave_valid cycle (value and cycle number) into a queue,
// and a negedge monitor pops and compares.
module tb_bus_slave;

    localparam logic [1:0] SLAVE_ID = 2'b10;

    logic clock = 1'b0;
    logic reset;
    logic valid, addr_tx, burst_mode, data_tx, read_en;
    logic slave_ready, slave_valid, data_rx;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic b;
        int   cyc;
    } exp_t;
    exp_t sb[$];

    logic [7:0] ref_mem [4096];
    bit         known [4096];
    logic [11:0] last_base = 12'h0;
    int          last_n = 0;

    bus_slave #(.SLAVE_ID(SLAVE_ID), .MEM_AW(12)) dut (
        .clock(clock), .reset(reset), .valid(valid), .addr_tx(addr_tx),
        .burst_mode(burst_mode), .data_tx(data_tx), .read_en(read_en),
        .slave_ready(slave_ready), .slave_valid(slave_valid), .data_rx(data_rx)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every slave_valid cycle must match the head of the queue
    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_output: got nothing expected bit %0b at cycle %0d", sb[0].b, sb[0].cyc);
            void'(sb.pop_front());
        end
        if (slave_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got slave_valid=1 data_rx=%0b expected idle at cycle %0d", data_rx, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (data_rx !== e.b || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL read_bit: got %0b at cycle %0d expected %0b at cycle %0d", data_rx, cyc, e.b, e.cyc);
                end
            end
        end
    end

    // One frame: valid held for len cycles, optional reset during cycle rcyc
    task automatic frame(input bit rd, input logic [13:0] a, input logic [2:0] bc,
                         input logic [63:0] d, input int len, input int rcyc);
        int n, start, eff, last;
        bit match;
        logic [11:0] base;
        logic [7:0] tmp;
        n = int'(bc) + 1;
        base = a[11:0];
        match = (a[13:12] == SLAVE_ID);
        eff = (rcyc >= 0 && rcyc < len) ? rcyc : len;
        last = eff == len ? len - 1 : rcyc;
        @(posedge clock); #1;
        start = cyc;
        if (match) begin
            if (rd) begin
                for (int i = 0; i < 8 * n; i++) begin
                    if (15 + i < eff) begin
                        tmp = ref_mem[base + 12'(i / 8)];
                        sb.push_back('{tmp[i % 8], start + 15 + i});
                    end
                end
            end else begin
                for (int k = 0; k < n; k++) begin
                    if (14 + 8 * k + 7 < eff) begin
                        ref_mem[base + 12'(k)] = d[8 * k +: 8];
                        known[base + 12'(k)] = 1'b1;
                    end
                end
`ifdef SLAVE_WRITE_ACK_EN
                if (14 + 8 * n - 1 < eff) sb.push_back('{1'b0, start + 14 + 8 * n});
`endif
            end
        end
        for (int c = 0; c <= last; c++) begin
            if (c > 0) begin
                @(posedge clock); #1;
            end
            valid = 1'b1;
            read_en = rd;
            addr_tx = (c < 14) ? a[c] : 1'($urandom);
            burst_mode = (c < 3) ? bc[c] : 1'($urandom);
            data_tx = (!rd && c >= 14 && c < 14 + 8 * n) ? d[c - 14] : 1'($urandom);
            if (c == 1) begin
                #2 chk("ready_low_in_frame", slave_ready, 1'b0);
            end
            if (c == rcyc) begin
                #1 reset = 1'b1;
                #1;
                chk("reset_valid", slave_valid, 1'b0);
                chk("reset_data_rx", data_rx, 1'b0);
                chk("reset_ready", slave_ready, 1'b1);
            end
        end
        @(posedge clock); #1;
        valid = 1'b0;
        if (reset) begin
            reset = 1'b0;
            chk("ready_after_reset", slave_ready, 1'b1);
        end else begin
            #2 chk("ready_low_until_valid_drop", slave_ready, 1'b0);
        end
        @(posedge clock); #1;
        chk("ready_back", slave_ready, 1'b1);
    endtask

    initial begin
        bit rd;
        logic [2:0] bc;
        logic [11:0] base;
        logic [1:0] id;
        logic [63:0] d;
        int n, full, len;

        for (int i = 0; i < 4096; i++) known[i] = 1'b0;
        reset = 1'b1;
        valid = 1'b0; addr_tx = 1'b0; burst_mode = 1'b0; data_tx = 1'b0; read_en = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_ready", slave_ready, 1'b1);
        chk("rst_valid", slave_valid, 1'b0);
        chk("rst_data_rx", data_rx, 1'b0);
        reset = 1'b0;

        // Single-byte write then read at 0xCB2 (D5 reads 1,0,1,0,1,0,1,1)
        frame(0, 14'b10110010110010, 3'd0, 64'hD5, 14 + 8 + 2, -1);
        frame(1, 14'b10110010110010, 3'd0, 64'h0, 15 + 8 + 2, -1);

        // Four-byte burst across the top of memory, then read back
        frame(0, {SLAVE_ID, 12'hFFE}, 3'd3, 64'h44332211, 14 + 32 + 1, -1);
        frame(1, {SLAVE_ID, 12'hFFE}, 3'd3, 64'h0, 15 + 32 + 3, -1);

        // Other slave ID: ignored; location still reads D5
        frame(0, {2'b01, 12'hCB2}, 3'd0, 64'hAA, 14 + 8 + 2, -1);
        frame(1, {SLAVE_ID, 12'hCB2}, 3'd0, 64'h0, 15 + 8 + 1, -1);

        // Abort after 4 bits of byte 2: only byte 1 lands
        frame(0, {SLAVE_ID, 12'h100}, 3'd1, 64'h6655, 14 + 16 + 2, -1);
        frame(0, {SLAVE_ID, 12'h100}, 3'd1, 64'hBBAA, 26, -1);
        frame(1, {SLAVE_ID, 12'h100}, 3'd1, 64'h0, 15 + 16 + 2, -1);

        // Reset during read bit 3, then a normal read
        frame(1, {SLAVE_ID, 12'h100}, 3'd1, 64'h0, 15 + 16 + 2, 18);
        frame(1, {SLAVE_ID, 12'h100}, 3'd1, 64'h0, 15 + 16 + 2, -1);

        // Randomized frames
        for (int r = 0; r < 40; r++) begin
            bc = 3'($urandom_range(0, 7));
            base = 12'($urandom);
            rd = 1'($urandom);
            if (rd && last_n > 0 && $urandom_range(0, 2) != 0) begin
                base = last_base;
                bc = 3'(last_n - 1);
            end
            n = int'(bc) + 1;
            if (rd) begin
                for (int k = 0; k < n; k++) if (!known[base + 12'(k)]) rd = 1'b0;
            end
            id = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 1)) : SLAVE_ID;
            d = {$urandom, $urandom};
            full = rd ? 15 + 8 * n : 14 + 8 * n;
            len = full + $urandom_range(1, 3);
            if ($urandom_range(0, 3) == 0) len = $urandom_range(2, full - 1);
            if (!rd && id == SLAVE_ID && len > full) begin
                last_base = base;
                last_n = n;
            end
            frame(rd, {id, base}, bc, d, len, -1);
        end

        repeat (4) @(posedge clock);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
